// File: rtl/call_stack_pkg.sv
// Shared types and pointer helpers for the call/return stack.
package call_stack_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} stk_op_e;

  // Pointer arithmetic wraps by explicit compare so DEPTH need not be a power of two.
  function automatic int unsigned stk_ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int unsigned stk_ptr_dec(input int unsigned ptr, input int unsigned depth);
    return (ptr == 32'd0) ? depth - 32'd1 : ptr - 32'd1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: register array, one synchronous write port, one asynchronous read port.
module stack_mem #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// LIFO for call/return addresses with occupancy, full/empty flags and sticky error flags.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned DATA_W       = 11,
  parameter int unsigned DEPTH        = 16,
  parameter bit          WRAP_ON_FULL = 1'b0,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  stk_op_e           op;
  logic [PTR_W-1:0]  top, top_nxt, ptr_inc, ptr_dec, waddr;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] rdata;
  logic              we, ovf_set, udf_set;

  assign ptr_inc = PTR_W'(stk_ptr_inc(32'(top), DEPTH));
  assign ptr_dec = PTR_W'(stk_ptr_dec(32'(top), DEPTH));

  // Flags come from the count so a wrapped pointer never makes them ambiguous.
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign dout  = empty ? '0 : rdata;

  always_comb begin
    op = OP_NONE;
    unique case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NONE;
    endcase
  end

  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    we        = 1'b0;
    waddr     = ptr_inc;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          we        = 1'b1;
          top_nxt   = ptr_inc;
          count_nxt = count + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
          // Wrap mode: the slot above top is the oldest entry when full.
          if (WRAP_ON_FULL) begin
            we      = 1'b1;
            top_nxt = ptr_inc;
          end
        end
      end
      OP_POP: begin
        if (!empty) begin
          top_nxt   = ptr_dec;
          count_nxt = count - CNT_W'(1);
        end else begin
          udf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (!empty) begin
          waddr = top;
        end else begin
          top_nxt   = ptr_inc;
          count_nxt = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top       <= PTR_W'(DEPTH - 1);
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top       <= top_nxt;
      count     <= count_nxt;
      // A new error in the same cycle as err_clr wins.
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= udf_set | (underflow & ~err_clr);
    end
  end

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we & ~reset),
    .waddr (waddr),
    .wdata (din),
    .raddr (top),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: drop-on-full and wrap-on-full instances share one stimulus stream.
module tb_call_stack;

  localparam int DW = 11;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout      [2];
  logic [CW-1:0] count     [2];
  logic          empty     [2];
  logic          full      [2];
  logic          overflow  [2];
  logic          underflow [2];

  typedef struct packed {
    logic [DW-1:0] dout;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mv [2][DP];
  int            mc [2];
  bit            mo [2];
  bit            mu [2];
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  call_stack #(.DATA_W(DW), .DEPTH(DP), .WRAP_ON_FULL(1'b0)) u_drop (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .dout(dout[0]), .empty(empty[0]), .full(full[0]), .count(count[0]),
    .overflow(overflow[0]), .underflow(underflow[0])
  );

  call_stack #(.DATA_W(DW), .DEPTH(DP), .WRAP_ON_FULL(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .dout(dout[1]), .empty(empty[1]), .full(full[1]), .count(count[1]),
    .overflow(overflow[1]), .underflow(underflow[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: entries kept bottom..top in an ordered array; wrap shifts out the oldest.
  task automatic model_step(input bit rst, input bit p, input bit o, input bit clr,
                            input logic [DW-1:0] d);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      bit no;
      bit nu;
      no = 1'b0;
      nu = 1'b0;
      if (rst) begin
        mc[k] = 0;
        mo[k] = 1'b0;
        mu[k] = 1'b0;
      end else begin
        if (p && o) begin
          if (mc[k] == 0) begin
            mv[k][0] = d;
            mc[k] = 1;
          end else begin
            mv[k][mc[k]-1] = d;
          end
        end else if (p) begin
          if (mc[k] < DP) begin
            mv[k][mc[k]] = d;
            mc[k]++;
          end else begin
            no = 1'b1;
            if (k == 1) begin
              for (int i = 0; i < DP - 1; i++) mv[k][i] = mv[k][i+1];
              mv[k][DP-1] = d;
            end
          end
        end else if (o) begin
          if (mc[k] > 0) mc[k]--;
          else nu = 1'b1;
        end
        mo[k] = no || (mo[k] && !clr);
        mu[k] = nu || (mu[k] && !clr);
      end
      e.dout  = (mc[k] > 0) ? mv[k][mc[k]-1] : '0;
      e.count = CW'(mc[k]);
      e.empty = (mc[k] == 0);
      e.full  = (mc[k] == DP);
      e.ovf   = mo[k];
      e.udf   = mu[k];
      sb_q.push_back(e);
    end
  endtask

  task automatic cycle(input bit rst, input bit p, input bit o, input bit clr,
                       input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    reset = rst; push = p; pop = o; err_clr = clr; din = d;
    model_step(rst, p, o, clr, d);
    @(posedge clk);
    #1;
    chk("sb_depth", 32'(sb_q.size()), 32'(2));
    for (int k = 0; k < 2; k++) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk($sformatf("u%0d_dout", k),  32'(dout[k]),      32'(e.dout));
        chk($sformatf("u%0d_count", k), 32'(count[k]),     32'(e.count));
        chk($sformatf("u%0d_empty", k), 32'(empty[k]),     32'(e.empty));
        chk($sformatf("u%0d_full", k),  32'(full[k]),      32'(e.full));
        chk($sformatf("u%0d_ovf", k),   32'(overflow[k]),  32'(e.ovf));
        chk($sformatf("u%0d_udf", k),   32'(underflow[k]), 32'(e.udf));
      end
    end
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] seq [5];
    seq[0] = 11'h101; seq[1] = 11'h202; seq[2] = 11'h303; seq[3] = 11'h404; seq[4] = 11'h7FF;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_dout", 32'(dout[0]), 32'h0);
    chk("rst_empty", 32'(empty[0]), 32'h1);
    chk("rst_full", 32'(full[0]), 32'h0);

    // Basic push then pop
    for (int i = 0; i < 3; i++) do_push(seq[i]);
    chk("t1_dout", 32'(dout[0]), 32'h303);
    chk("t1_count", 32'(count[0]), 32'd3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("t1_pop_dout", 32'(dout[0]), 32'h202);
    chk("t1_pop_count", 32'(count[0]), 32'd2);

    // Reset wins over a coincident push
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 11'h7AB);
    chk("t6_count", 32'(count[0]), 32'd0);
    chk("t6_empty", 32'(empty[0]), 32'h1);
    chk("t6_dout", 32'(dout[0]), 32'h0);

    // Underflow then recovery
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("t4_udf", 32'(underflow[0]), 32'h1);
    chk("t4_dout", 32'(dout[0]), 32'h0);
    do_push(11'h0AA);
    chk("t4_push_dout", 32'(dout[0]), 32'h0AA);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
    chk("t4_clr_vs_new", 32'(underflow[0]), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("t4_clr", 32'(underflow[0]), 32'h0);

    // Full-stack policies side by side
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) do_push(seq[i]);
    chk("t2_full", 32'(full[0]), 32'h1);
    chk("t2_count", 32'(count[0]), 32'd4);
    chk("t2_dout", 32'(dout[0]), 32'h404);
    chk("t2_ovf", 32'(overflow[0]), 32'h1);
    chk("t3_wrap_dout", 32'(dout[1]), 32'h7FF);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("t2_clr", 32'(overflow[0]), 32'h0);

    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 5; i++) do_push(DW'(i));
    chk("t3_count", 32'(count[1]), 32'd4);
    chk("t3_ovf", 32'(overflow[1]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_pop%0d", i), 32'(dout[1]), 32'(5 - i));
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    end
    chk("t3_empty", 32'(empty[1]), 32'h1);
    chk("t3_dout0", 32'(dout[1]), 32'h0);

    // Replace on a populated and on an empty stack
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    do_push(11'h101);
    do_push(11'h202);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 11'h055);
    chk("t5_dout", 32'(dout[0]), 32'h055);
    chk("t5_count", 32'(count[0]), 32'd2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 11'h033);
    chk("t5e_count", 32'(count[0]), 32'd1);
    chk("t5e_dout", 32'(dout[0]), 32'h033);
    chk("t5e_err", 32'({overflow[0], underflow[0]}), 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
